// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: the side-effect enable vector and the mem/wb payload layout.
// The width of the payload struct sets the default data width of every stage buffer.
package cpu_pkg;

    localparam int STAGE_WE_W = 8;

    typedef logic [STAGE_WE_W-1:0] stage_we_t;

    // Bit positions inside stage_we_t; bit 7 is spare.
    localparam int WE_WREG  = 0;
    localparam int WE_HILO  = 1;
    localparam int WE_CP0   = 2;
    localparam int WE_TLBP  = 3;
    localparam int WE_TLBR  = 4;
    localparam int WE_TLBWI = 5;
    localparam int WE_TLBWR = 6;

    typedef struct packed {
        logic [31:0] wreg_data;
        logic [31:0] hilo_data;
        logic [31:0] cp0_data;
    } mem_wb_payload_t;

    localparam int PAYLOAD_W = $bits(mem_wb_payload_t);

endpackage

// File: rtl/pipe_stage_entry.sv
// One storage slot of a pipeline boundary buffer: a valid flag plus payload and enables.
// load wins over clear; clear drops only the valid flag so the payload stays readable.
module pipe_stage_entry
    import cpu_pkg::*;
#(
    parameter int DATA_W = PAYLOAD_W,
    parameter int WE_W   = STAGE_WE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [WE_W-1:0]   d_we,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [WE_W-1:0]   we
);

    // NOTE: the payload is reset too, because the head slot drives dn_data directly and it
    // must read zero after reset even when bubble clearing is disabled.
    // NOTE: sequential state is written with <= only, so every slot samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            we    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            we    <= d_we;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready boundary register between CPU stages, built from DEPTH slots that
// shift toward the head on pop; slot 0 is the head, slot 1 the skid.
module pipe_stage_buf
    import cpu_pkg::*;
#(
    parameter int DATA_W          = PAYLOAD_W,
    parameter int WE_W            = STAGE_WE_W,
    parameter int DEPTH           = 2,
    parameter bit CLEAR_ON_BUBBLE = 1'b1,
    parameter int CNT_W           = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       up_valid,
    output logic                       up_ready,
    input  logic [DATA_W-1:0]          up_data,
    input  logic [WE_W-1:0]            up_we,
    output logic                       dn_valid,
    input  logic                       dn_ready,
    output logic [DATA_W-1:0]          dn_data,
    output logic [WE_W-1:0]            dn_we,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           bubble_cnt
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  e_valid;
    logic [DEPTH-1:0]  e_load;
    logic [DEPTH-1:0]  e_clear;
    logic [DATA_W-1:0] e_data [DEPTH];
    logic [WE_W-1:0]   e_we   [DEPTH];
    logic [DATA_W-1:0] d_data [DEPTH];
    logic [WE_W-1:0]   d_we   [DEPTH];

    logic             push;
    logic             pop;
    logic [OCC_W-1:0] occ_after_pop;
    logic [OCC_W-1:0] occ_next;

    // Valid slots are always contiguous from the head, so the count is also the push slot.
    // NOTE: the accumulator gets its default before the loop; without it this would latch.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(e_valid[i]);
        end
    end

    assign push          = up_valid & up_ready & ~flush;
    assign pop           = e_valid[0] & dn_ready & ~flush;
    assign occ_after_pop = occupancy - OCC_W'(pop);
    assign occ_next      = occ_after_pop + OCC_W'(push);

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i < DEPTH - 1) begin : g_shift
            // A new entry lands just behind the survivors; everything else moves up on pop.
            assign e_load[i] = (push && occ_after_pop == OCC_W'(i)) || (pop && e_valid[i+1]);
            assign d_data[i] = (push && occ_after_pop == OCC_W'(i)) ? up_data : e_data[i+1];
            assign d_we[i]   = (push && occ_after_pop == OCC_W'(i)) ? up_we   : e_we[i+1];
        end else begin : g_tail
            assign e_load[i] = push && occ_after_pop == OCC_W'(i);
            assign d_data[i] = up_data;
            assign d_we[i]   = up_we;
        end

        assign e_clear[i] = flush | pop;

        pipe_stage_entry #(
            .DATA_W (DATA_W),
            .WE_W   (WE_W)
        ) u_entry (
            .clk    (clk),
            .rst    (rst),
            .load   (e_load[i]),
            .clear  (e_clear[i]),
            .d_data (d_data[i]),
            .d_we   (d_we[i]),
            .valid  (e_valid[i]),
            .data   (e_data[i]),
            .we     (e_we[i])
        );
    end

    if (DEPTH == 1) begin : g_ready_comb
        assign up_ready = ~e_valid[0] | dn_ready;
    end else begin : g_ready_reg
        // Registered so downstream ready never reaches upstream combinationally.
        logic ready_q;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                ready_q <= 1'b1;
            end else begin
                ready_q <= occ_next < OCC_W'(DEPTH);
            end
        end

        assign up_ready = ready_q;
    end

    assign dn_valid = e_valid[0];
    assign dn_we    = e_valid[0] ? e_we[0] : '0;
    assign dn_data  = (e_valid[0] || !CLEAR_ON_BUBBLE) ? e_data[0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!e_valid[0] && bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule
